// File: rtl/vga_timing_pkg.sv
// Shared raster timing constants (1080p60 defaults) and the count type used by the video pipeline.
package vga_timing_pkg;
  localparam int COUNT_W   = 12;
  localparam int MAX_TOTAL = 1 << COUNT_W;

  localparam int H_ACTIVE = 1920;
  localparam int H_FP     = 88;
  localparam int H_SYNC   = 44;
  localparam int H_BP     = 148;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int V_ACTIVE = 1080;
  localparam int V_FP     = 4;
  localparam int V_SYNC   = 5;
  localparam int V_BP     = 36;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  typedef logic [COUNT_W-1:0] count_t;
endpackage

// File: rtl/timing_axis_gen.sv
// One raster axis: wrapping counter with registered sync/blank derived from the next count.
// wrap is combinational: high in the step cycle that returns the count to 0.
module timing_axis_gen
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE   = 1920,
  parameter int FP       = 88,
  parameter int SYNC     = 44,
  parameter int BP       = 148,
  parameter bit SYNC_POS = 1'b1
) (
  input  logic   i_pclk,
  input  logic   i_rst,
  input  logic   i_step,
  output count_t count,
  output logic   sync,
  output logic   blank,
  output logic   wrap
);
  localparam int TOTAL = ACTIVE + FP + SYNC + BP;

  if (TOTAL > MAX_TOTAL) begin : g_total_check
    $error("timing_axis_gen: total of %0d exceeds %0d-bit count range", TOTAL, COUNT_W);
  end

  localparam count_t LAST       = count_t'(TOTAL - 1);
  localparam count_t ACTIVE_C   = count_t'(ACTIVE);
  localparam count_t SYNC_START = count_t'(ACTIVE + FP);
  localparam count_t SYNC_END   = count_t'(ACTIVE + FP + SYNC);

  count_t count_nxt;

  assign wrap = i_step && (count == LAST);

  always_comb begin
    count_nxt = count;
    if (wrap)        count_nxt = '0;
    else if (i_step) count_nxt = count + count_t'(1);
  end

  // Flags follow count_nxt so they always describe the pixel registered alongside them.
  always_ff @(posedge i_pclk or posedge i_rst) begin
    if (i_rst) begin
      count <= '0;
      blank <= 1'b0;
      sync  <= ~SYNC_POS;
    end else if (i_step) begin
      count <= count_nxt;
      blank <= (count_nxt >= ACTIVE_C);
      sync  <= ((count_nxt >= SYNC_START) && (count_nxt < SYNC_END)) ? SYNC_POS : ~SYNC_POS;
    end
  end
endmodule

// File: rtl/vga_timing_gen.sv
// Free-running raster timing source for the pixel pipeline; all outputs registered.
// Optional o_frame_cnt frame counter is built when VGA_TIMING_FRAME_CNT_EN is defined.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = vga_timing_pkg::H_ACTIVE,
  parameter int H_FP     = vga_timing_pkg::H_FP,
  parameter int H_SYNC   = vga_timing_pkg::H_SYNC,
  parameter int H_BP     = vga_timing_pkg::H_BP,
  parameter int V_ACTIVE = vga_timing_pkg::V_ACTIVE,
  parameter int V_FP     = vga_timing_pkg::V_FP,
  parameter int V_SYNC   = vga_timing_pkg::V_SYNC,
  parameter int V_BP     = vga_timing_pkg::V_BP,
  parameter bit SYNC_POS = 1'b1
) (
  input  logic               i_pclk,
  input  logic               i_rst,
  input  logic               i_en,
  output logic [COUNT_W-1:0] o_hcount,
  output logic               o_hsync,
  output logic               o_hblnk,
  output logic [COUNT_W-1:0] o_vcount,
  output logic               o_vsync,
  output logic               o_vblnk,
  output logic               o_frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
  ,
  output logic [15:0]        o_frame_cnt
`endif
);
  logic h_wrap;
  logic v_wrap;

  timing_axis_gen #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .SYNC_POS(SYNC_POS)
  ) u_h_axis (
    .i_pclk(i_pclk), .i_rst(i_rst), .i_step(i_en),
    .count(o_hcount), .sync(o_hsync), .blank(o_hblnk), .wrap(h_wrap)
  );

  // h_wrap already includes i_en, so lines only advance on enabled line ends.
  timing_axis_gen #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .SYNC_POS(SYNC_POS)
  ) u_v_axis (
    .i_pclk(i_pclk), .i_rst(i_rst), .i_step(h_wrap),
    .count(o_vcount), .sync(o_vsync), .blank(o_vblnk), .wrap(v_wrap)
  );

  always_ff @(posedge i_pclk or posedge i_rst) begin
    if (i_rst)     o_frame_start <= 1'b0;
    else if (i_en) o_frame_start <= v_wrap;
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  always_ff @(posedge i_pclk or posedge i_rst) begin
    if (i_rst)       o_frame_cnt <= '0;
    else if (v_wrap) o_frame_cnt <= o_frame_cnt + 16'd1;
  end
`endif
endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench on a shrunken raster: 16 pixels x 11 lines (hsync 10..12, vsync lines 7..8).
module tb_vga_timing_gen;
`ifdef VGA_TIMING_FRAME_CNT_EN
  localparam bit SP = 1'b0;
`else
  localparam bit SP = 1'b1;
`endif
  localparam bit IDLE = ~SP;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [11:0] hcount, vcount;
  logic        hsync, hblnk, vsync, vblnk, fs;
`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] frame_cnt;
`endif

  int checks = 0;
  int errors = 0;

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .SYNC_POS(SP)
  ) dut (
    .i_pclk(clk), .i_rst(rst), .i_en(en),
    .o_hcount(hcount), .o_hsync(hsync), .o_hblnk(hblnk),
    .o_vcount(vcount), .o_vsync(vsync), .o_vblnk(vblnk),
    .o_frame_start(fs)
`ifdef VGA_TIMING_FRAME_CNT_EN
    , .o_frame_cnt(frame_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int n_hs;
  int n_fs;

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_hcount", 32'(hcount), 0);
    check("rst_vcount", 32'(vcount), 0);
    check("rst_hsync", 32'(hsync), 32'(IDLE));
    check("rst_vsync", 32'(vsync), 32'(IDLE));
    check("rst_hblnk", 32'(hblnk), 0);
    check("rst_vblnk", 32'(vblnk), 0);
    check("rst_fs", 32'(fs), 0);
`ifdef VGA_TIMING_FRAME_CNT_EN
    check("rst_frame_cnt", 32'(frame_cnt), 0);
`endif

    rst = 1'b0;
    en  = 1'b1;
    step(1);
    check("first_hcount", 32'(hcount), 1);
    check("first_fs", 32'(fs), 0);
    step(6);
    check("h7_hblnk", 32'(hblnk), 0);
    step(1);
    check("h8_hcount", 32'(hcount), 8);
    check("h8_hblnk", 32'(hblnk), 1);
    check("h8_hsync", 32'(hsync), 32'(IDLE));
    step(2);
    check("h10_hsync", 32'(hsync), 32'(SP));
    step(2);
    check("h12_hsync", 32'(hsync), 32'(SP));
    step(1);
    check("h13_hsync", 32'(hsync), 32'(IDLE));
    step(2);
    check("h15_hcount", 32'(hcount), 15);
    check("h15_vcount", 32'(vcount), 0);
    step(1);
    check("wrap_hcount", 32'(hcount), 0);
    check("wrap_vcount", 32'(vcount), 1);
    check("wrap_hblnk", 32'(hblnk), 0);
    check("wrap_fs", 32'(fs), 0);

    n_hs = 0;
    for (int i = 0; i < 16; i++) begin
      if (hsync == SP) n_hs++;
      step(1);
    end
    check("hsync_width", 32'(n_hs), 3);
    check("line2_vcount", 32'(vcount), 2);

    step(64);
    check("v6_vcount", 32'(vcount), 6);
    check("v6_vblnk", 32'(vblnk), 1);
    check("v6_vsync", 32'(vsync), 32'(IDLE));
    step(15);
    check("v6_end_vsync", 32'(vsync), 32'(IDLE));
    step(1);
    check("v7_hcount", 32'(hcount), 0);
    check("v7_vsync", 32'(vsync), 32'(SP));
    step(31);
    check("v8_end_vsync", 32'(vsync), 32'(SP));
    step(1);
    check("v9_vsync", 32'(vsync), 32'(IDLE));
    step(31);
    check("last_hcount", 32'(hcount), 15);
    check("last_vcount", 32'(vcount), 10);
    check("last_vblnk", 32'(vblnk), 1);

    en = 1'b0;
    step(7);
    check("hold_hcount", 32'(hcount), 15);
    check("hold_vcount", 32'(vcount), 10);
    check("hold_fs", 32'(fs), 0);
    en = 1'b1;
    step(1);
    check("frame_hcount", 32'(hcount), 0);
    check("frame_vcount", 32'(vcount), 0);
    check("frame_fs", 32'(fs), 1);
    check("frame_vblnk", 32'(vblnk), 0);
    check("frame_vsync", 32'(vsync), 32'(IDLE));
    en = 1'b0;
    step(3);
    check("fs_held", 32'(fs), 1);
    check("fs_held_hcount", 32'(hcount), 0);
    en = 1'b1;
    step(1);
    check("fs_drop", 32'(fs), 0);
    check("fs_drop_hcount", 32'(hcount), 1);

    n_fs = 0;
    for (int i = 0; i < 176; i++) begin
      step(1);
      if (fs) n_fs++;
    end
    check("fs_per_frame", 32'(n_fs), 1);
    check("frame2_hcount", 32'(hcount), 1);
    check("frame2_vcount", 32'(vcount), 0);
`ifdef VGA_TIMING_FRAME_CNT_EN
    check("frame_cnt_2", 32'(frame_cnt), 2);
`endif

    step(123);
    check("mid_hcount", 32'(hcount), 12);
    check("mid_vcount", 32'(vcount), 7);
    check("mid_hsync", 32'(hsync), 32'(SP));
    check("mid_vsync", 32'(vsync), 32'(SP));
    check("mid_hblnk", 32'(hblnk), 1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_hcount", 32'(hcount), 0);
    check("arst_vcount", 32'(vcount), 0);
    check("arst_hsync", 32'(hsync), 32'(IDLE));
    check("arst_vsync", 32'(vsync), 32'(IDLE));
    check("arst_hblnk", 32'(hblnk), 0);
    check("arst_vblnk", 32'(vblnk), 0);
`ifdef VGA_TIMING_FRAME_CNT_EN
    check("arst_frame_cnt", 32'(frame_cnt), 0);
`endif
    step(2);
    rst = 1'b0;
    step(1);
    check("restart_hcount", 32'(hcount), 1);
    check("restart_vcount", 32'(vcount), 0);
    check("restart_fs", 32'(fs), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
